// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shift register with parallel load, serial MSB input and LSB tap.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             lsb
);

    // Load has priority so a restart never mixes with a pending shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {ser_in, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Operand sequencer / result collector around an external single-bit full adder.
// Optional subtract mode (A-B, two's complement) enabled by defining SERIAL_ADD_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start; fa_* driven 0, result held
// SHIFT | one bit pair per clock to the full adder, LSB first
// DONE  | one-cycle done pulse, result and carry held
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    state_t            state_q;
    state_t            state_d;
    logic              load;
    logic              shift_en;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
    logic              a_lsb;
    logic              b_lsb;
    logic [WIDTH-1:0]  a_q_unused;
    logic [WIDTH-1:0]  b_q_unused;
    logic              sum_lsb_unused;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADD_SUB_EN
    // Subtract: invert B and force carry-in so the adder computes A + ~B + 1.
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b_in;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            carry_q <= carry_load;
        end else if (shift_en) begin
            cnt_q   <= cnt_q + 1'b1;
            carry_q <= fa_cout;
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (a_in),
        .shift_en (shift_en),
        .ser_in   (1'b0),
        .q        (a_q_unused),
        .lsb      (a_lsb)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (b_load),
        .shift_en (shift_en),
        .ser_in   (1'b0),
        .q        (b_q_unused),
        .lsb      (b_lsb)
    );

    // Sum fills from the MSB end so bit 0 lands in place after WIDTH shifts.
    serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val ('0),
        .shift_en (shift_en),
        .ser_in   (fa_sum),
        .q        (sum_out),
        .lsb      (sum_lsb_unused)
    );

    assign fa_a   = shift_en & a_lsb;
    assign fa_b   = shift_en & b_lsb;
    assign fa_cin = shift_en & carry_q;
    assign cout   = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl with a behavioural full adder.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub_i;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub_i),
`endif
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Effective B and carry-in as seen by the adder for add/sub.
    function automatic longint b_eff(input logic [W-1:0] b, input logic s);
        return s ? longint'(~b) : longint'(b);
    endfunction

    function automatic longint c_eff(input logic c, input logic s);
        return s ? 1 : longint'(c);
    endfunction

    function automatic longint ref_total(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        return longint'(a) + b_eff(b, s) + c_eff(c, s);
    endfunction

    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input bit extra);
        longint total, bb, cc, mask, carry_j;
        total = ref_total(a, b, c, s);
        bb    = b_eff(b, s);
        cc    = c_eff(c, s);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; sub_i = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
        for (int j = 0; j <= W; j++) begin
            if (j > 0) @(negedge clk);
            if (j < W) begin
                mask    = (longint'(1) << j) - 1;
                carry_j = ((longint'(a) & mask) + (bb & mask) + cc) >> j;
                check("busy_shift", busy, 1);
                check("done_early", done, 0);
                check("fa_a", fa_a, (longint'(a) >> j) & 1);
                check("fa_b", fa_b, (bb >> j) & 1);
                check("fa_cin", fa_cin, carry_j & 1);
            end else begin
                check("done_pulse", done, 1);
                check("busy_done", busy, 1);
                check("sum_out", sum_out, total & ((1 << W) - 1));
                check("cout", cout, (total >> W) & 1);
            end
            if (extra && (j == 2 || j == 8)) begin
                start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("sum_held", sum_out, total & ((1 << W) - 1));
        check("cout_held", cout, (total >> W) & 1);
        check("fa_idle", {fa_a, fa_b, fa_cin}, 0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] ra, rb;
        logic rc;
        longint total;

        rst_n = 1'b0; start = 1'b0; sub_i = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", cout, 0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst_n = 1'b1;

        do_add(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        do_add(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        check("lit_12_34", sum_out, 8'h46);

        // Reset in the middle of a shift.
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum_out, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_fa", {fa_a, fa_b, fa_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_add(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            do_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'($urandom));
`else
            do_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, bit'($urandom));
`endif
        end

        // Start held high: relaunch every W+2 cycles.
        @(negedge clk);
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        a_in = ra; b_in = rb; cin = rc; sub_i = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 40);
            check("b2b_latency", cyc, (k == 0) ? W + 1 : W + 2);
            total = ref_total(ra, rb, rc, 1'b0);
            check("b2b_sum", sum_out, total & ((1 << W) - 1));
            check("b2b_cout", cout, (total >> W) & 1);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            a_in = ra; b_in = rb; cin = rc;
            if (k == 2) start = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", busy, 0);

`ifdef SERIAL_ADD_SUB_EN
        do_add(8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
        check("sub_5_7", {cout, sum_out}, 9'h0FE);
        do_add(8'd7, 8'd5, 1'b0, 1'b1, 1'b0);
        check("sub_7_5", {cout, sum_out}, 9'h102);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
